// File: rtl/regfile_pkg.sv
// Shared types and helpers for the sync_register_file datapath register bank.
package regfile_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam int unsigned ZERO_ADDR = 0;

  // Even parity over a zero-extended word; extension does not change the result.
  function automatic logic parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: request register, write-first bypass, hard-zero masking,
// parity check (parity check only when REGFILE_PARITY_EN is defined).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned Width   = 8,
  parameter int unsigned Depth   = 5,
  parameter int unsigned ZeroReg = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [Depth-1:0] addr_i,
  input  logic [Width-1:0] mem_data_i,
  input  logic             mem_par_i,
  input  logic             wr_en_i,
  input  logic [Depth-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             wr_par_i,
  output logic [Width-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             rd_perr_o
);

  logic [Width-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic             perr_d, perr_q;
  logic [Width-1:0] sel_data;
  logic             sel_par;
  logic             is_zero;

  always_comb begin
    sel_data = mem_data_i;
    sel_par  = mem_par_i;
    if (wr_en_i && (wr_addr_i == addr_i)) begin
      sel_data = wr_data_i;
      sel_par  = wr_par_i;
    end
    is_zero = (ZeroReg != 0) && (addr_i == Depth'(ZERO_ADDR));
    valid_d = req_i;
    data_d  = data_q;
    perr_d  = 1'b0;
    if (req_i) begin
      data_d = is_zero ? '0 : sel_data;
`ifdef REGFILE_PARITY_EN
      perr_d = !is_zero && (sel_par != parity(64'(sel_data)));
`endif
    end
  end

`ifndef REGFILE_PARITY_EN
  logic unused_par;
  assign unused_par = sel_par;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign rd_perr_o  = perr_q;

endmodule

// File: rtl/sync_register_file.sv
// Clocked 2**Depth x Width register file: one write port, two read ports, clear sequencer.
// Optional per-word even parity when REGFILE_PARITY_EN is defined.
module sync_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned Width   = 8,
  parameter int unsigned Depth   = 5,
  parameter int unsigned ZeroReg = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  output logic             busy_o,
  input  logic             wr_en_i,
  input  logic [Depth-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             wr_inject_i,
  output logic             wr_ready_o,
  input  logic             rd_en_a_i,
  input  logic [Depth-1:0] rd_addr_a_i,
  output logic [Width-1:0] rd_data_a_o,
  output logic             rd_valid_a_o,
  output logic             rd_perr_a_o,
  input  logic             rd_en_b_i,
  input  logic [Depth-1:0] rd_addr_b_i,
  output logic [Width-1:0] rd_data_b_o,
  output logic             rd_valid_b_o,
  output logic             rd_perr_b_o
);

  localparam int unsigned Words = 2 ** Depth;

  state_t           state_d, state_q;
  logic [Depth-1:0] ptr_d, ptr_q;
  logic             busy_d, busy_q;
  logic             wr_ready_d, wr_ready_q;

  logic [Width-1:0] mem_q [Words];
  logic             mem_we;
  logic [Depth-1:0] mem_idx;
  logic [Width-1:0] mem_wdata;
  logic             mem_wpar;
  logic             wr_fire;
  logic             wr_par;
  logic             rd_par_a, rd_par_b;

`ifdef REGFILE_PARITY_EN
  logic par_q [Words];
  assign wr_par   = parity(64'(wr_data_i)) ^ wr_inject_i;
  assign rd_par_a = par_q[rd_addr_a_i];
  assign rd_par_b = par_q[rd_addr_b_i];
`else
  logic unused_inject;
  assign unused_inject = wr_inject_i;
  assign wr_par   = 1'b0;
  assign rd_par_a = 1'b0;
  assign rd_par_b = 1'b0;
`endif

  // Writes to a hard-zero word 0 are discarded here, so they never reach the bypass either.
  assign wr_fire = wr_ready_q && wr_en_i &&
                   !((ZeroReg != 0) && (wr_addr_i == Depth'(ZERO_ADDR)));

  always_comb begin
    mem_we    = wr_fire;
    mem_idx   = wr_addr_i;
    mem_wdata = wr_data_i;
    mem_wpar  = wr_par;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = ptr_q;
      mem_wdata = '0;
      mem_wpar  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (clear_i) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + Depth'(1);
          if (ptr_q == '1) state_d = READY;
        end
      end
      READY: begin
        if (clear_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    busy_d     = (state_d == CLEAR);
    wr_ready_d = (state_d == READY);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
`ifdef REGFILE_PARITY_EN
      par_q[mem_idx] <= mem_wpar;
`endif
    end
  end

`ifndef REGFILE_PARITY_EN
  logic unused_wpar;
  assign unused_wpar = mem_wpar;
`endif

  assign busy_o     = busy_q;
  assign wr_ready_o = wr_ready_q;

  regfile_read_port #(.Width(Width), .Depth(Depth), .ZeroReg(ZeroReg)) u_port_a (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (rd_en_a_i && wr_ready_q),
    .addr_i     (rd_addr_a_i),
    .mem_data_i (mem_q[rd_addr_a_i]),
    .mem_par_i  (rd_par_a),
    .wr_en_i    (wr_fire),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .wr_par_i   (wr_par),
    .rd_data_o  (rd_data_a_o),
    .rd_valid_o (rd_valid_a_o),
    .rd_perr_o  (rd_perr_a_o)
  );

  regfile_read_port #(.Width(Width), .Depth(Depth), .ZeroReg(ZeroReg)) u_port_b (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (rd_en_b_i && wr_ready_q),
    .addr_i     (rd_addr_b_i),
    .mem_data_i (mem_q[rd_addr_b_i]),
    .mem_par_i  (rd_par_b),
    .wr_en_i    (wr_fire),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .wr_par_i   (wr_par),
    .rd_data_o  (rd_data_b_o),
    .rd_valid_o (rd_valid_b_o),
    .rd_perr_o  (rd_perr_b_o)
  );

endmodule

// File: tb/tb_sync_register_file.sv
// Bench for sync_register_file: ZeroReg=0 and ZeroReg=1 instances on shared stimulus,
// checked each cycle against an array-based model of the register bank.
module tb_sync_register_file;

  localparam int N = 32;

`ifdef REGFILE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clear, wr_en, wr_inject, rd_en_a, rd_en_b;
  logic [4:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data;

  logic       busy [2];
  logic       wr_ready [2];
  logic [7:0] rdata [4];
  logic       rvalid [4];
  logic       rperr [4];

  int total = 0;
  int bad   = 0;

  // Model state: [0] plain bank, [1] hard-zero bank; result slots 0/1 = u0 A/B, 2/3 = u1 A/B.
  int         clr_left;
  logic [7:0] m [2][N];
  bit         pbad [2][N];
  bit         ev [4];
  logic [7:0] ed [4];
  bit         ep [4];

  always #5 clk = ~clk;

  sync_register_file #(.Width(8), .Depth(5), .ZeroReg(0)) u0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[0]),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_inject_i(wr_inject),
    .wr_ready_o(wr_ready[0]),
    .rd_en_a_i(rd_en_a), .rd_addr_a_i(rd_addr_a), .rd_data_a_o(rdata[0]),
    .rd_valid_a_o(rvalid[0]), .rd_perr_a_o(rperr[0]),
    .rd_en_b_i(rd_en_b), .rd_addr_b_i(rd_addr_b), .rd_data_b_o(rdata[1]),
    .rd_valid_b_o(rvalid[1]), .rd_perr_b_o(rperr[1])
  );

  sync_register_file #(.Width(8), .Depth(5), .ZeroReg(1)) u1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[1]),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_inject_i(wr_inject),
    .wr_ready_o(wr_ready[1]),
    .rd_en_a_i(rd_en_a), .rd_addr_a_i(rd_addr_a), .rd_data_a_o(rdata[2]),
    .rd_valid_a_o(rvalid[2]), .rd_perr_a_o(rperr[2]),
    .rd_en_b_i(rd_en_b), .rd_addr_b_i(rd_addr_b), .rd_data_b_o(rdata[3]),
    .rd_valid_b_o(rvalid[3]), .rd_perr_b_o(rperr[3])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i), 8'(busy[i]), 8'(clr_left != 0));
      chk($sformatf("wr_ready%0d", i), 8'(wr_ready[i]), 8'(clr_left == 0));
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid%0d", k), 8'(rvalid[k]), 8'(ev[k]));
      chk($sformatf("data%0d", k), rdata[k], ed[k]);
      chk($sformatf("perr%0d", k), 8'(rperr[k]), 8'(ep[k]));
    end
  endtask

  task automatic model_reset();
    clr_left = N;
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < N; i++) begin
        m[z][i]    = 8'h00;
        pbad[z][i] = 1'b0;
      end
    for (int k = 0; k < 4; k++) begin
      ev[k] = 1'b0;
      ed[k] = 8'h00;
      ep[k] = 1'b0;
    end
  endtask

  task automatic idle();
    clear = 0; wr_en = 0; wr_inject = 0; rd_en_a = 0; rd_en_b = 0;
  endtask

  // One clock: advance the model from the current inputs, then compare after the edge.
  task automatic cycle();
    bit rdy;
    bit en [2];
    logic [4:0] ra [2];
    rdy = (clr_left == 0);
    en[0] = rd_en_a; en[1] = rd_en_b;
    ra[0] = rd_addr_a; ra[1] = rd_addr_b;
    if (rdy && wr_en) begin
      m[0][wr_addr] = wr_data;
      pbad[0][wr_addr] = wr_inject;
      if (wr_addr != 0) begin
        m[1][wr_addr] = wr_data;
        pbad[1][wr_addr] = wr_inject;
      end
    end
    for (int z = 0; z < 2; z++)
      for (int p = 0; p < 2; p++) begin
        ev[2*z+p] = en[p] && rdy;
        ep[2*z+p] = 1'b0;
        if (en[p] && rdy) begin
          ed[2*z+p] = (z == 1 && ra[p] == 0) ? 8'h00 : m[z][ra[p]];
          ep[2*z+p] = PAR && !(z == 1 && ra[p] == 0) && pbad[z][ra[p]];
        end
      end
    if (clear) begin
      clr_left = N;
      for (int z = 0; z < 2; z++)
        for (int i = 0; i < N; i++) begin
          m[z][i]    = 8'h00;
          pbad[z][i] = 1'b0;
        end
    end else if (!rdy) begin
      clr_left--;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle();
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Initial clear: 32 busy cycles, then everything reads zero.
    repeat (N) cycle();
    for (int i = 0; i < N; i++) begin
      rd_en_a = 1; rd_addr_a = 5'(i);
      rd_en_b = 1; rd_addr_b = 5'(N - 1 - i);
      cycle();
    end
    idle();
    cycle();

    // Write then read next cycle.
    wr_en = 1; wr_addr = 5'd3; wr_data = 8'hA5;
    cycle();
    idle();
    rd_en_a = 1; rd_addr_a = 5'd3;
    cycle();
    idle();
    cycle();

    // Same-cycle write and dual read of the same address: write-first.
    wr_en = 1; wr_addr = 5'd7; wr_data = 8'h3C;
    rd_en_a = 1; rd_addr_a = 5'd7; rd_en_b = 1; rd_addr_b = 5'd7;
    cycle();
    idle();
    cycle();

    // Fill, then clear mid-readback; reads during clear are dropped.
    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 8'(8'h11 + i);
      cycle();
    end
    idle();
    for (int i = 0; i < N; i++) begin
      rd_en_a = 1; rd_addr_a = 5'(i); rd_en_b = 1; rd_addr_b = 5'(i);
      clear = (i == 10);
      wr_en = (i > 10); wr_addr = 5'(i); wr_data = 8'hEE;
      cycle();
    end
    idle();
    repeat (N - 20) cycle();
    for (int i = 0; i < N; i++) begin
      rd_en_a = 1; rd_addr_a = 5'(i);
      cycle();
    end
    idle();

    // Word 0: discarded on the hard-zero instance, including the bypass path.
    wr_en = 1; wr_addr = 5'd0; wr_data = 8'hFF;
    rd_en_a = 1; rd_addr_a = 5'd0;
    cycle();
    idle();
    rd_en_b = 1; rd_addr_b = 5'd0;
    cycle();
    idle();

    // Parity injection then clean rewrite.
    wr_en = 1; wr_addr = 5'd5; wr_data = 8'h07; wr_inject = 1;
    cycle();
    idle();
    rd_en_a = 1; rd_addr_a = 5'd5;
    cycle();
    wr_en = 1; wr_addr = 5'd5; wr_data = 8'h07; wr_inject = 0;
    rd_en_b = 1; rd_addr_b = 5'd5;
    cycle();
    idle();
    rd_en_a = 1; rd_addr_a = 5'd5;
    cycle();
    idle();

    // Reset in the middle of a clear restarts the full 32-cycle sequence.
    clear = 1;
    cycle();
    idle();
    repeat (10) cycle();
    apply_reset();
    repeat (N) cycle();

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 5'($urandom_range(0, N - 1));
      wr_data   = 8'($urandom);
      wr_inject = ($urandom_range(0, 7) == 0);
      rd_en_a   = 1'($urandom_range(0, 1));
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, N - 1));
      rd_en_b   = 1'($urandom_range(0, 1));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 5'($urandom_range(0, N - 1));
      clear     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
